// File: rtl/icache_linefill_ctrl.sv
// Refill response path: collects downstream rx beats for one MSHR entry into a
// full line, writes line+tag to the selected icache way, then pulses linefill_done.
module icache_linefill_ctrl #(
  parameter int unsigned ENTRY_NUM      = 8,
  parameter int unsigned TXNID_WIDTH    = 3,
  parameter int unsigned BEAT_WIDTH     = 128,
  parameter int unsigned BEATS_PER_LINE = 4,
  parameter int unsigned INDEX_WIDTH    = 7,
  parameter int unsigned TAG_WIDTH      = 20
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 downstream_rxdat_vld,
  output logic                                 downstream_rxdat_rdy,
  input  logic [TXNID_WIDTH-1:0]               downstream_rxdat_txnid,
  input  logic [BEAT_WIDTH-1:0]                downstream_rxdat_data,
  output logic [TXNID_WIDTH-1:0]               mshr_lkup_txnid,
  input  logic [INDEX_WIDTH-1:0]               mshr_lkup_index,
  input  logic [TAG_WIDTH-1:0]                 mshr_lkup_tag,
  input  logic                                 mshr_lkup_way,
  output logic                                 fill_wr_vld,
  input  logic                                 fill_wr_rdy,
  output logic                                 fill_wr_way,
  output logic [INDEX_WIDTH-1:0]               fill_wr_index,
  output logic [TAG_WIDTH-1:0]                 fill_wr_tag,
  output logic [BEAT_WIDTH*BEATS_PER_LINE-1:0] fill_wr_data,
  output logic [ENTRY_NUM-1:0]                 linefill_done,
  output logic                                 fill_err
);

  localparam int unsigned CNT_W  = $clog2(BEATS_PER_LINE) + 1;
  localparam int unsigned LINE_W = BEAT_WIDTH * BEATS_PER_LINE;

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t                   state_q, state_d;
  logic [TXNID_WIDTH-1:0]   txnid_q;
  logic                     way_q;
  logic [INDEX_WIDTH-1:0]   index_q;
  logic [TAG_WIDTH-1:0]     tag_q;
  logic [LINE_W-1:0]        line_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     err_q;

  logic rx_hs;
  logic txnid_hit;
  logic last_slot;

  assign rx_hs     = downstream_rxdat_vld & downstream_rxdat_rdy;
  assign txnid_hit = (downstream_rxdat_txnid == txnid_q);
  assign last_slot = (cnt_q == CNT_W'(BEATS_PER_LINE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d              = state_q;
    downstream_rxdat_rdy = 1'b0;
    fill_wr_vld          = 1'b0;
    mshr_lkup_txnid      = txnid_q;
    linefill_done        = '0;
    case (state_q)
      IDLE: begin
        downstream_rxdat_rdy = 1'b1;
        mshr_lkup_txnid      = downstream_rxdat_txnid;
        if (downstream_rxdat_vld) state_d = COLLECT;
      end
      COLLECT: begin
        downstream_rxdat_rdy = 1'b1;
        if (downstream_rxdat_vld && txnid_hit && last_slot) state_d = WRITE;
      end
      WRITE: begin
        fill_wr_vld = 1'b1;
        if (fill_wr_rdy) state_d = DONE;
      end
      DONE: begin
        linefill_done[txnid_q] = 1'b1;
        state_d                = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Foreign-txnid beats in COLLECT are drained (rdy stays high) but never stored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txnid_q <= '0;
      way_q   <= 1'b0;
      index_q <= '0;
      tag_q   <= '0;
      line_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rx_hs) begin
            txnid_q                 <= downstream_rxdat_txnid;
            way_q                   <= mshr_lkup_way;
            index_q                 <= mshr_lkup_index;
            tag_q                   <= mshr_lkup_tag;
            line_q[0 +: BEAT_WIDTH] <= downstream_rxdat_data;
            cnt_q                   <= CNT_W'(1);
          end
        end
        COLLECT: begin
          if (rx_hs) begin
            if (txnid_hit) begin
              for (int unsigned i = 0; i < BEATS_PER_LINE; i++) begin
                if (cnt_q == CNT_W'(i)) line_q[i*BEAT_WIDTH +: BEAT_WIDTH] <= downstream_rxdat_data;
              end
              cnt_q <= cnt_q + 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        DONE:    cnt_q <= '0;
        default: ;
      endcase
    end
  end

  assign fill_wr_way   = way_q;
  assign fill_wr_index = index_q;
  assign fill_wr_tag   = tag_q;
  assign fill_wr_data  = line_q;
  assign fill_err      = err_q;

endmodule

// File: tb/tb_icache_linefill_ctrl.sv
// Directed bench for icache_linefill_ctrl: line assembly, gaps, write backpressure,
// back-to-back lines, txnid mismatch and mid-line reset.
module tb_icache_linefill_ctrl;

  logic         clk;
  logic         rst_n;
  logic         rx_vld;
  logic         rx_rdy;
  logic [2:0]   rx_txnid;
  logic [127:0] rx_data;
  logic [2:0]   lkup_txnid;
  logic [6:0]   lkup_index;
  logic [19:0]  lkup_tag;
  logic         lkup_way;
  logic         wr_vld;
  logic         wr_rdy;
  logic         wr_way;
  logic [6:0]   wr_index;
  logic [19:0]  wr_tag;
  logic [511:0] wr_data;
  logic [7:0]   done;
  logic         err;

  int n_cmp = 0;
  int n_err = 0;

  icache_linefill_ctrl #(
    .ENTRY_NUM(8), .TXNID_WIDTH(3), .BEAT_WIDTH(128),
    .BEATS_PER_LINE(4), .INDEX_WIDTH(7), .TAG_WIDTH(20)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .downstream_rxdat_vld(rx_vld), .downstream_rxdat_rdy(rx_rdy),
    .downstream_rxdat_txnid(rx_txnid), .downstream_rxdat_data(rx_data),
    .mshr_lkup_txnid(lkup_txnid), .mshr_lkup_index(lkup_index),
    .mshr_lkup_tag(lkup_tag), .mshr_lkup_way(lkup_way),
    .fill_wr_vld(wr_vld), .fill_wr_rdy(wr_rdy), .fill_wr_way(wr_way),
    .fill_wr_index(wr_index), .fill_wr_tag(wr_tag), .fill_wr_data(wr_data),
    .linefill_done(done), .fill_err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish (observed timeout, expected finish)");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] bt(input logic [7:0] b);
    return {16{b}};
  endfunction

  function automatic logic [511:0] ln(input logic [7:0] b0, b1, b2, b3);
    return {bt(b3), bt(b2), bt(b1), bt(b0)};
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [2:0] id, input logic [7:0] b);
    rx_vld   = 1'b1;
    rx_txnid = id;
    rx_data  = bt(b);
    tick();
    rx_vld   = 1'b0;
  endtask

  task automatic set_lkup(input logic [6:0] idx, input logic [19:0] tg, input logic w);
    lkup_index = idx;
    lkup_tag   = tg;
    lkup_way   = w;
  endtask

  logic [511:0] held;

  initial begin
    rst_n = 1'b0; rx_vld = 1'b0; rx_txnid = '0; rx_data = '0; wr_rdy = 1'b1;
    set_lkup(7'h00, 20'h0, 1'b0);
    tick(); tick();

    // Reset state
    chk("rst_rdy", rx_rdy, 1);
    chk("rst_wr_vld", wr_vld, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_data", wr_data, 0);
    chk("rst_index", wr_index, 0);
    rst_n = 1'b1;
    tick();

    // Single line, txnid 3
    rx_txnid = 3'd3; #1;
    chk("idle_lkup_follows_rx", lkup_txnid, 3);
    set_lkup(7'h15, 20'hABCDE, 1'b1);
    beat(3'd3, 8'hA0);
    set_lkup(7'h7F, 20'h11111, 1'b0);
    chk("collect_lkup_captured", lkup_txnid, 3);
    beat(3'd3, 8'hA1);
    beat(3'd3, 8'hA2);
    chk("pre_last_no_vld", wr_vld, 0);
    beat(3'd3, 8'hA3);
    chk("s_wr_vld", wr_vld, 1);
    chk("s_rdy_low", rx_rdy, 0);
    chk("s_data", wr_data, ln(8'hA0, 8'hA1, 8'hA2, 8'hA3));
    chk("s_index", wr_index, 7'h15);
    chk("s_tag", wr_tag, 20'hABCDE);
    chk("s_way", wr_way, 1);
    chk("s_done_not_yet", done, 0);
    tick();
    chk("s_done", done, 8'b0000_1000);
    chk("s_wr_vld_drop", wr_vld, 0);
    tick();
    chk("s_done_one_cycle", done, 0);
    chk("s_rdy_back", rx_rdy, 1);

    // Gapped beats, txnid 4
    set_lkup(7'h2A, 20'h12345, 1'b0);
    for (int i = 0; i < 4; i++) begin
      beat(3'd4, 8'hB0 + 8'(i));
      if (i < 3) begin
        tick(); tick();
        chk("g_no_vld_in_gap", wr_vld, 0);
      end
    end
    chk("g_wr_vld", wr_vld, 1);
    chk("g_data", wr_data, ln(8'hB0, 8'hB1, 8'hB2, 8'hB3));
    chk("g_index", wr_index, 7'h2A);
    chk("g_way", wr_way, 0);
    tick();
    chk("g_done", done, 8'b0001_0000);
    tick();

    // Write backpressure, txnid 5
    set_lkup(7'h33, 20'hFEDCB, 1'b1);
    beat(3'd5, 8'hC0);
    beat(3'd5, 8'hC1);
    beat(3'd5, 8'hC2);
    wr_rdy = 1'b0;
    beat(3'd5, 8'hC3);
    held = ln(8'hC0, 8'hC1, 8'hC2, 8'hC3);
    rx_vld = 1'b1; rx_txnid = 3'd5; rx_data = bt(8'hEE);
    for (int i = 0; i < 5; i++) begin
      chk("bp_vld_held", wr_vld, 1);
      chk("bp_rdy_low", rx_rdy, 0);
      chk("bp_data_held", wr_data, held);
      chk("bp_tag_held", wr_tag, 20'hFEDCB);
      chk("bp_no_done", done, 0);
      tick();
    end
    rx_vld = 1'b0;
    wr_rdy = 1'b1;
    chk("bp_vld_at_rdy", wr_vld, 1);
    tick();
    chk("bp_done", done, 8'b0010_0000);
    tick();

    // Back-to-back lines: txnid 1 then txnid 6 with vld held high
    set_lkup(7'h01, 20'h00001, 1'b0);
    beat(3'd1, 8'h10);
    set_lkup(7'h66, 20'h66666, 1'b1);
    beat(3'd1, 8'h11);
    beat(3'd1, 8'h12);
    rx_vld = 1'b1; rx_txnid = 3'd1; rx_data = bt(8'h13);
    tick();
    rx_txnid = 3'd6; rx_data = bt(8'h60);
    chk("bb1_data", wr_data, ln(8'h10, 8'h11, 8'h12, 8'h13));
    chk("bb1_index", wr_index, 7'h01);
    chk("bb_rdy_write", rx_rdy, 0);
    tick();
    chk("bb1_done", done, 8'b0000_0010);
    chk("bb_rdy_done", rx_rdy, 0);
    tick();
    chk("bb_rdy_idle", rx_rdy, 1);
    tick();
    chk("bb2_first_accepted", lkup_txnid, 6);
    chk("bb2_rdy_collect", rx_rdy, 1);
    rx_vld = 1'b0;
    beat(3'd6, 8'h61);
    beat(3'd6, 8'h62);
    beat(3'd6, 8'h63);
    chk("bb2_data", wr_data, ln(8'h60, 8'h61, 8'h62, 8'h63));
    chk("bb2_tag", wr_tag, 20'h66666);
    chk("bb2_way", wr_way, 1);
    tick();
    chk("bb2_done", done, 8'b0100_0000);
    tick();

    // Txnid mismatch: txnid 5 beat injected into txnid 2 line
    set_lkup(7'h22, 20'h22222, 1'b0);
    beat(3'd2, 8'h20);
    beat(3'd2, 8'h21);
    chk("mm_err_before", err, 0);
    beat(3'd5, 8'h55);
    chk("mm_err_set", err, 1);
    chk("mm_no_vld", wr_vld, 0);
    beat(3'd2, 8'h22);
    beat(3'd2, 8'h23);
    chk("mm_wr_vld", wr_vld, 1);
    chk("mm_data", wr_data, ln(8'h20, 8'h21, 8'h22, 8'h23));
    tick();
    chk("mm_done", done, 8'b0000_0100);
    tick();
    chk("mm_err_sticky", err, 1);

    // Reset after beat 2 of 4
    set_lkup(7'h44, 20'h44444, 1'b1);
    beat(3'd7, 8'h70);
    beat(3'd7, 8'h71);
    rst_n = 1'b0; #1;
    chk("ar_rdy", rx_rdy, 1);
    chk("ar_wr_vld", wr_vld, 0);
    chk("ar_done", done, 0);
    chk("ar_err_cleared", err, 0);
    chk("ar_data_cleared", wr_data, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("ar_no_done_after", done, 0);
    set_lkup(7'h0C, 20'hC0C0C, 1'b0);
    beat(3'd0, 8'hD0);
    beat(3'd0, 8'hD1);
    beat(3'd0, 8'hD2);
    chk("ar_no_early_write", wr_vld, 0);
    beat(3'd0, 8'hD3);
    chk("ar_wr_vld", wr_vld, 1);
    chk("ar_data", wr_data, ln(8'hD0, 8'hD1, 8'hD2, 8'hD3));
    chk("ar_index", wr_index, 7'h0C);
    chk("ar_tag", wr_tag, 20'hC0C0C);
    tick();
    chk("ar_done_fresh", done, 8'b0000_0001);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
